rocc_cmd_queue: RTL and testbench
=================================

ROCC_CMD_QUEUE -- requirements
Module: rocc_cmd_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, width of rs1/rs2 operands.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum responses in flight; 1..15.
REQ-004 SHALL have ports, in order:
 clock  in  1  rising-edge clock
 reset  in  1  synchronous, active-high reset
 in_valid  in  1  core command valid
 in_ready  out  1  queue can accept
 in_funct  in  7  instruction funct
 in_rd  in  5  destination register
 in_xd  in  1  command expects response
 in_rs1  in  XLEN  operand 1
 in_rs2  in  XLEN  operand 2
 out_valid  out  1  head command offered to accelerator
 out_ready  in  1  accelerator accepts
 out_funct  out  7  head funct
 out_rd  out  5  head rd
 out_xd  out  1  head xd
 out_rs1  out  XLEN  head rs1
 out_rs2  out  XLEN  head rs2
 resp_valid  in  1  accelerator response valid (monitored)
 resp_ready  in  1  core accepts response (monitored)
 busy  out  1  queue non-empty or response outstanding
 count  out  clog2(DEPTH)+1  entries held
 outstanding  out  clog2(MAX_OUT+1)  responses owed
 err_underflow  out  1  sticky: response with none owed

Function
REQ-005 Enqueue fire = in_valid && in_ready; dequeue fire = out_valid && out_ready; resp fire = resp_valid && resp_ready.
REQ-006 in_ready SHALL equal (count != DEPTH); no enqueue when full, even with simultaneous dequeue.
REQ-007 Storage SHALL be registered; entry enqueued at edge N visible on out_* no earlier than cycle after N (no combinational in-to-out bypass).
REQ-008 out_* fields SHALL show head entry whenever count != 0; values undefined-but-stable when empty are not checked.
REQ-009 out_valid SHALL equal (count != 0) && !(out_xd && outstanding == MAX_OUT).
REQ-010 Order SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-011 count: +1 on enqueue only, -1 on dequeue only, unchanged on both.
REQ-012 outstanding: +1 on dequeue with out_xd=1, -1 on resp fire when outstanding != 0, unchanged when both occur.
REQ-013 Resp fire with outstanding == 0 and no same-cycle xd dequeue SHALL leave outstanding 0 and set err_underflow; with same-cycle xd dequeue, outstanding stays 0, no error.
REQ-014 busy SHALL equal (count != 0) || (outstanding != 0), combinational from registers.
REQ-015 Commands with xd=0 SHALL never alter outstanding.
REQ-016 No output SHALL combinationally depend on in_valid, in_* data, out_ready, resp_valid or resp_ready.

Reset
REQ-017 On clock edge with reset=1: count=0, pointers=0, outstanding=0, err_underflow=0; out_valid=0, busy=0, in_ready=1 next cycle.
REQ-018 Reset mid-operation SHALL discard all queued entries and owed responses; same-cycle fires ignored.
REQ-019 err_underflow SHALL clear only by reset.

Verification
REQ-020 Enqueue funct=0x01 rd=3 xd=1 rs1=0x10 rs2=0x20, out_ready=0 -> next cycle out_valid=1, out_rd=3, out_rs1=0x10, count=1, busy=1.
REQ-021 Enqueue 4 commands back-to-back, out_ready=0 (DEPTH=4) -> count=4, in_ready=0; 5th in_valid not accepted; drain -> data in order 1..4, count=0.
REQ-022 MAX_OUT=4: dequeue 4 xd=1 commands, no resp -> outstanding=4, 5th xd=1 head out_valid=0; xd=0 head still offered; one resp fire -> outstanding=3, xd=1 head offered.
REQ-023 outstanding=2; same cycle xd=1 dequeue and resp fire -> outstanding=2; simultaneous enqueue+dequeue at count=2 -> count=2.
REQ-024 Resp fire at outstanding=0 -> err_underflow=1, outstanding=0, persists until reset.
REQ-025 count=3, outstanding=2, assert reset one cycle -> count=0, outstanding=0, busy=0, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/rocc_cmd_queue.sv
// rocc_cmd_queue
// Command FIFO between the core and a RoCC-style accelerator. It also tracks how
// many responses the accelerator still owes. The head command is held back when it
// expects a response (xd=1) and MAX_OUT responses are already outstanding.
// A response that arrives when none is owed sets a sticky underflow flag.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_*                command from the core (valid/ready handshake)
//   out_*               head command offered to the accelerator (valid/ready)
//   resp_valid/ready    response handshake, monitored only
//   busy                queue non-empty or a response still owed
//   count               entries held
//   outstanding         responses owed
//   err_underflow       sticky: a response arrived with none owed
module rocc_cmd_queue #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [6:0]                     in_funct,
  input  logic [4:0]                     in_rd,
  input  logic                           in_xd,
  input  logic [XLEN-1:0]                in_rs1,
  input  logic [XLEN-1:0]                in_rs2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [6:0]                     out_funct,
  output logic [4:0]                     out_rd,
  output logic                           out_xd,
  output logic [XLEN-1:0]                out_rs1,
  output logic [XLEN-1:0]                out_rs2,
  input  logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           busy,
  output logic [$clog2(DEPTH):0]         count,
  output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
  output logic                           err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int EW = 13 + 2 * XLEN;

  // Entry layout: {funct, rd, xd, rs1, rs2}
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [OW-1:0] outstanding_reg, outstanding_next;
  logic          err_reg, err_next;

  logic enq_fire, deq_fire, resp_fire, xd_issue;

  // Head is read straight from the storage registers, so a freshly written entry
  // only becomes visible after the write edge; there is no input-to-output path.
  assign head      = mem[rd_ptr_reg];
  assign out_funct = head[EW-1 -: 7];
  assign out_rd    = head[EW-8 -: 5];
  assign out_xd    = head[2*XLEN];
  assign out_rs1   = head[2*XLEN-1 -: XLEN];
  assign out_rs2   = head[XLEN-1:0];

  assign in_ready      = (count_reg != CW'(DEPTH));
  assign out_valid     = (count_reg != '0) && !(out_xd && (outstanding_reg == OW'(MAX_OUT)));
  assign busy          = (count_reg != '0) || (outstanding_reg != '0);
  assign count         = count_reg;
  assign outstanding   = outstanding_reg;
  assign err_underflow = err_reg;

  assign enq_fire  = in_valid && in_ready;
  assign deq_fire  = out_valid && out_ready;
  assign resp_fire = resp_valid && resp_ready;
  assign xd_issue  = deq_fire && out_xd;

  always_comb begin
    count_next = count_reg;
    if (enq_fire && !deq_fire)
      count_next = count_reg + CW'(1);
    else if (deq_fire && !enq_fire)
      count_next = count_reg - CW'(1);
  end

  // A response in the same cycle as an xd issue cancels it out, even at zero
  // outstanding: the response is treated as answering the command just issued.
  always_comb begin
    outstanding_next = outstanding_reg;
    err_next         = err_reg;
    if (xd_issue && !resp_fire)
      outstanding_next = outstanding_reg + OW'(1);
    else if (resp_fire && !xd_issue) begin
      if (outstanding_reg != '0)
        outstanding_next = outstanding_reg - OW'(1);
      else
        err_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire)
      mem[wr_ptr_reg] <= {in_funct, in_rd, in_xd, in_rs1, in_rs2};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (deq_fire) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// tb_rocc_cmd_queue
// Directed scenarios followed by a random phase. A queue-based reference model
// predicts every DUT output once per cycle.
module tb_rocc_cmd_queue;
  localparam int XLEN    = 64;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_funct;
  logic [4:0]      in_rd;
  logic            in_xd;
  logic [XLEN-1:0] in_rs1, in_rs2;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_funct;
  logic [4:0]      out_rd;
  logic            out_xd;
  logic [XLEN-1:0] out_rs1, out_rs2;
  logic            resp_valid, resp_ready;
  logic            busy;
  logic [$clog2(DEPTH):0]       count;
  logic [$clog2(MAX_OUT+1)-1:0] outstanding;
  logic            err_underflow;

  always #5 clock = ~clock;

  rocc_cmd_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_rd(in_rd), .in_xd(in_xd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_funct(out_funct), .out_rd(out_rd), .out_xd(out_xd),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .busy(busy), .count(count), .outstanding(outstanding),
    .err_underflow(err_underflow)
  );

  typedef struct {
    logic [6:0]      funct;
    logic [4:0]      rd;
    logic            xd;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } cmd_t;

  cmd_t m_q[$];
  int   m_out;
  bit   m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The model's expected outputs, derived from queue contents and owed responses
  function automatic bit m_in_ready();
    return m_q.size() != DEPTH;
  endfunction

  function automatic bit m_out_valid();
    if (m_q.size() == 0) return 1'b0;
    return !(m_q[0].xd && m_out == MAX_OUT);
  endfunction

  task automatic check_state();
    chk("count", count, m_q.size());
    chk("in_ready", in_ready, m_in_ready());
    chk("out_valid", out_valid, m_out_valid());
    chk("busy", busy, (m_q.size() != 0) || (m_out != 0));
    chk("outstanding", outstanding, m_out);
    chk("err_underflow", err_underflow, m_err);
    if (m_q.size() != 0) begin
      chk("out_funct", out_funct, m_q[0].funct);
      chk("out_rd", out_rd, m_q[0].rd);
      chk("out_xd", out_xd, m_q[0].xd);
      chk("out_rs1", out_rs1, m_q[0].rs1);
      chk("out_rs2", out_rs2, m_q[0].rs2);
    end
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit   enq, deq, rsp, deq_xd;
    cmd_t c;
    @(negedge clock);
    check_state();
    enq = in_valid && m_in_ready();
    deq = m_out_valid() && out_ready;
    rsp = resp_valid && resp_ready;
    c.funct = in_funct; c.rd = in_rd; c.xd = in_xd; c.rs1 = in_rs1; c.rs2 = in_rs2;
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      m_out = 0;
      m_err = 1'b0;
    end else begin
      deq_xd = 1'b0;
      if (deq) begin
        deq_xd = m_q[0].xd;
        void'(m_q.pop_front());
      end
      if (enq) m_q.push_back(c);
      if (deq && deq_xd && rsp) begin
        // response answers the command issued this cycle
      end else if (deq && deq_xd) m_out++;
      else if (rsp) begin
        if (m_out > 0) m_out--;
        else m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drive(input bit iv, input bit xd, input logic [4:0] rd,
                       input logic [XLEN-1:0] rs1, input bit ordy, input bit rsp);
    in_valid   = iv;
    in_xd      = xd;
    in_rd      = rd;
    in_funct   = 7'h01;
    in_rs1     = rs1;
    in_rs2     = rs1 + 64'h10;
    out_ready  = ordy;
    resp_valid = rsp;
    resp_ready = rsp;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    m_out = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);

    // Single command appears one cycle after enqueue
    drive(1, 1, 5'd3, 64'h10, 0, 0);
    in_rs2 = 64'h20;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("single_out_valid", out_valid, 1'b1);
    chk("single_out_rd", out_rd, 5'd3);
    chk("single_out_rs1", out_rs1, 64'h10);
    chk("single_out_rs2", out_rs2, 64'h20);
    chk("single_count", count, 1);
    chk("single_busy", busy, 1'b1);
    tick();

    // Fill to DEPTH, refuse a fifth, then drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 5'(i), 64'(i), 0, 0);
      tick();
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 1'b0);
    drive(1, 0, 5'd5, 64'd5, 1, 0);
    tick();
    chk("full_no_enq_count", count, 3);
    chk("full_head_after_pop", out_rs1, 64'd2);
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 2; i <= 4; i++) begin
      chk("drain_order", out_rs1, 64'(i));
      tick();
    end
    chk("drain_count", count, 0);

    // Response limit holds back xd=1 heads but not xd=0 heads
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(i), 64'(100 + i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    chk("limit_outstanding", outstanding, 4);
    drive(1, 0, 5'd7, 64'h70, 0, 0);
    tick();
    drive(1, 1, 5'd8, 64'h80, 0, 0);
    tick();
    chk("limit_xd0_offered", out_valid, 1'b1);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("limit_xd1_blocked", out_valid, 1'b0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("limit_after_resp", outstanding, 3);
    chk("limit_xd1_offered", out_valid, 1'b1);

    // Issue and response in the same cycle cancel; enq+deq keeps count
    tick();
    chk("cancel_setup", outstanding, 2);
    drive(1, 1, 5'd9, 64'h90, 0, 0);
    tick();
    drive(1, 0, 5'd10, 64'hA0, 0, 0);
    tick();
    chk("cancel_count3", count, 3);
    drive(0, 0, 0, 0, 1, 1);
    tick();
    chk("cancel_outstanding", outstanding, 2);
    chk("cancel_count", count, 2);
    drive(1, 0, 5'd11, 64'hB0, 1, 0);
    tick();
    chk("enq_deq_count", count, 2);

    // Underflow is sticky until reset
    do_reset();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("underflow_set", err_underflow, 1'b1);
    chk("underflow_out", outstanding, 0);
    repeat (3) tick();
    chk("underflow_sticky", err_underflow, 1'b1);
    do_reset();
    chk("underflow_cleared", err_underflow, 1'b0);

    // Response alongside an xd issue at zero outstanding is not an underflow
    drive(1, 1, 5'd1, 64'h1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    tick();
    chk("zero_cancel_out", outstanding, 0);
    chk("zero_cancel_err", err_underflow, 1'b0);

    // Reset mid-operation discards everything, fires ignored
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 5'(i), 64'(i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 5'(i), 64'(i), 0, 0);
      tick();
    end
    chk("midreset_pre_count", count, 3);
    chk("midreset_pre_out", outstanding, 2);
    drive(1, 1, 5'd1, 64'h1, 1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("midreset_count", count, 0);
    chk("midreset_out", outstanding, 0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_in_ready", in_ready, 1'b1);
    chk("midreset_out_valid", out_valid, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      in_xd      = $urandom_range(0, 1);
      in_funct   = 7'($urandom);
      in_rd      = 5'($urandom);
      in_rs1     = {$urandom, $urandom};
      in_rs2     = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 99) < 55);
      resp_valid = ($urandom_range(0, 99) < 35);
      resp_ready = ($urandom_range(0, 99) < 80);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
